// File: rtl/pwm_duty_gen.sv
// pwm_duty_gen: turns the ABS-stage magnitude stream into the 8-bit LED PWM duty word.
// Each sample is scaled and saturated to 8 bits, and the largest sample of each
// 256-cycle frame is kept. A VU-meter style peak-hold with linear decay is then
// applied to that per-frame maximum. Duty only changes on frame boundaries, so the
// PWM stage never sees a mid-frame update.
module pwm_duty_gen #(
    parameter int IN_W        = 16,
    parameter int SHIFT       = 8,
    parameter int HOLD_FRAMES = 4,
    parameter int DECAY_STEP  = 2
) (
    input  logic            clk_pwm_out,
    input  logic            rst_n,
    input  logic            mag_valid,
    input  logic [IN_W-1:0] mag_data,
    output logic [7:0]      pwm_data,
    output logic            frame_start,
    output logic            peak_active
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        DECAY = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_INIT  = 8'(HOLD_FRAMES);
    localparam logic [7:0] DECAY_AMT  = 8'(DECAY_STEP);
    localparam logic [IN_W-1:0] SAT_LIMIT = IN_W'(255);

    logic [7:0]      fcnt_q;
    logic            frameEnd;

    logic [IN_W-1:0] shifted;
    logic [7:0]      sample;
    logic [7:0]      validSample;
    logic [7:0]      cand;

    logic [7:0]      frameMax_q, frameMax_d;

    state_t          state_q, state_d;
    logic [7:0]      pk_q, pk_d;
    logic [7:0]      holdCnt_q, holdCnt_d;

    logic [7:0]      pwmData_q;
    logic            frameStart_q;
    logic            peakActive_q;

    assign frameEnd = (fcnt_q == 8'hFF);

    // Free-running frame counter, aligned with the PWM counter released from the same reset
    always_ff @(posedge clk_pwm_out or negedge rst_n) begin
        if (!rst_n) begin
            fcnt_q <= 8'd0;
        end else begin
            fcnt_q <= fcnt_q + 8'd1;
        end
    end

    // Scale the incoming sample and saturate it into 8 bits; also form the frame-end candidate
    always_comb begin
        shifted     = mag_data >> SHIFT;
        sample      = shifted[7:0];
        if (shifted > SAT_LIMIT) begin
            sample = 8'hFF;
        end
        validSample = mag_valid ? sample : 8'd0;
        cand        = (frameMax_q >= validSample) ? frameMax_q : validSample;
        frameMax_d  = frameEnd ? 8'd0 : cand;
    end

    // Running maximum of the current frame, cleared once the frame's candidate is taken
    always_ff @(posedge clk_pwm_out or negedge rst_n) begin
        if (!rst_n) begin
            frameMax_q <= 8'd0;
        end else begin
            frameMax_q <= frameMax_d;
        end
    end

    // Peak-hold/decay next-state logic; only acts at the frame-end cycle
    always_comb begin
        state_d   = state_q;
        pk_d      = pk_q;
        holdCnt_d = holdCnt_q;
        if (frameEnd) begin
            if ((cand >= pk_q) && (cand != 8'd0)) begin
                pk_d      = cand;
                holdCnt_d = HOLD_INIT;
                state_d   = HOLD;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_d = IDLE;
                    end
                    HOLD: begin
                        holdCnt_d = (holdCnt_q == 8'd0) ? 8'd0 : holdCnt_q - 8'd1;
                        if (holdCnt_q <= 8'd1) begin
                            state_d = DECAY;
                        end
                    end
                    DECAY: begin
                        if (pk_q > DECAY_AMT) begin
                            pk_d = pk_q - DECAY_AMT;
                        end else begin
                            pk_d    = 8'd0;
                            state_d = IDLE;
                        end
                    end
                    default: begin
                        pk_d    = 8'd0;
                        state_d = IDLE;
                    end
                endcase
            end
        end
    end

    // Peak-hold state register
    always_ff @(posedge clk_pwm_out or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pk_q      <= 8'd0;
            holdCnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            pk_q      <= pk_d;
            holdCnt_q <= holdCnt_d;
        end
    end

    // Registered outputs: duty and activity only move at frame end, visible when fcnt wraps to 0
    always_ff @(posedge clk_pwm_out or negedge rst_n) begin
        if (!rst_n) begin
            pwmData_q    <= 8'd0;
            frameStart_q <= 1'b0;
            peakActive_q <= 1'b0;
        end else begin
            frameStart_q <= frameEnd;
            if (frameEnd) begin
                pwmData_q    <= pk_d;
                peakActive_q <= (state_d != IDLE);
            end
        end
    end

    assign pwm_data    = pwmData_q;
    assign frame_start = frameStart_q;
    assign peak_active = peakActive_q;

endmodule
